// File: rtl/modulo_counter.sv
// Up/down counter with programmable modulus, wrap or saturate at the
// boundary, clear, clamped parallel load and a one-cycle overflow pulse.
module modulo_counter #(
   parameter int Size     = 5,
   parameter int Limit    = 2**Size-1,
   parameter bit Saturate = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic            up,
   input  logic            clear,
   input  logic            load,
   input  logic [Size-1:0] load_value,
   output logic [Size-1:0] count,
   output logic            terminal,
   output logic            overflow
);

   localparam logic [Size-1:0] Top = Size'(Limit);

   logic [Size-1:0] count_d;
   logic            overflow_d;
   logic [Size-1:0] clamped;
   logic            at_top;
   logic            at_zero;

   assign at_top   = (count == Top);
   assign at_zero  = (count == '0);
   assign clamped  = (load_value > Top) ? Top : load_value;
   assign terminal = up ? at_top : at_zero;

   // Boundary steps compare explicitly; the binary carry never wraps.
   always_comb begin
      count_d    = count;
      overflow_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = clamped;
      end else if (enable) begin
         if (up) begin
            if (at_top) begin
               overflow_d = 1'b1;
               count_d    = Saturate ? Top : '0;
            end else begin
               count_d = count + 1'b1;
            end
         end else begin
            if (at_zero) begin
               overflow_d = 1'b1;
               count_d    = Saturate ? '0 : Top;
            end else begin
               count_d = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         count    <= count_d;
         overflow <= overflow_d;
      end
   end

endmodule

// File: doc/modulo_counter.md
# modulo_counter

Parametrised up/down counter: the next generation of the team's fixed-width free-running counter. It adds:
- a programmable modulus;
- selectable wrap or saturate mode;
- count enable, direction, clear and parallel load;
- terminal-count and overflow indications.

It is the standard counting primitive for timers, address generators and Ruby-VPI bench exercises in this codebase.

## Interface
Parameters:
- Size, 5: counter width in bits; must be at least 1.
- Limit, 2**Size-1: highest count value (modulus is Limit+1); must satisfy 1 <= Limit <= 2**Size-1.
- Saturate, 0: 0 = wrap mode, 1 = saturate mode.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous reset, active-low; sampled on the rising edge of clock.
- enable  input  1  count-step request for this cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_value  input  Size  value to load.
- count  output  Size  current count; registered.
- terminal  output  1  combinational: (up && count==Limit) || (!up && count==0).
- overflow  output  1  registered one-cycle pulse; see Operation.

## Operation
- Per-edge priority, highest first: reset low, then clear, then load, then enable, otherwise hold.
- reset low: count=0, overflow=0. terminal follows the combinational rule, so it equals !up.
- clear=1: count=0, overflow=0. The enable and load inputs are ignored.
- load=1 (clear=0): count=min(load_value, Limit), overflow=0. An out-of-range load clamps to Limit and is never an error.
- enable=1 with up=1:
  - count<Limit: count+1.
  - count==Limit, wrap mode: count becomes 0 and overflow is 1 for the next cycle.
  - count==Limit, saturate mode: count holds at Limit and overflow is 1 for the next cycle, flagging the blocked step.
- enable=1 with up=0:
  - count>0: count-1.
  - count==0, wrap mode: count becomes Limit and overflow pulses.
  - count==0, saturate mode: count holds at 0 and overflow pulses.
- enable=0 with no clear/load: count holds and overflow is 0.
- overflow is high for exactly one cycle per boundary step. Consecutive blocked steps in saturate mode give overflow high on each of those cycles.
- Arithmetic uses Size bits with explicit boundary compare. count never exceeds Limit, even when Limit < 2**Size-1; the natural binary carry is never used for wrap.
- Direction may change on any cycle. The step always uses the value of up sampled on that edge.

## Timing
- All state updates on the rising edge of clock; there are no asynchronous paths.
- Latency is one cycle from enable, clear, load or reset sampled to the new count.
- overflow asserts in the same cycle that count shows the wrapped or held value.
- terminal has zero latency: it follows count and up combinationally and is valid whenever they are stable. Benches sample it at least #1 after the clock edge.
- Reset mid-count: on the edge where reset is sampled low, count becomes 0 and any pending overflow is dropped.
- Counting resumes on the first edge with reset high and enable=1.

## Test plan
All scenarios use Size=4, Limit=9.
- Reset: hold reset=0 for 2 edges with enable=1 and up=1 -> count=0, overflow=0, terminal=0. Set up=0 -> terminal=1.
- Wrap up: Saturate=0, reset released, enable=1, up=1 for 12 edges -> count goes 1..9, 0, 1, 2. overflow=1 only in the cycle count shows 0; terminal=1 only while count=9.
- Wrap down and saturate:
  - Saturate=0, load 0 then enable with up=0 -> count goes 9, 8.
  - Saturate=1, same stimulus -> count stays 0 and overflow is high on every enabled edge.
- Priority and clamp:
  - clear=1, load=1, enable=1 together with count=5 -> count=0.
  - Then load=1 with load_value=14 -> count=9 and overflow=0.
- Mid-operation reset: count running at 6, drop reset for 1 edge while enable=1 -> count=0 next cycle, then 1 on the following enabled edge.
